// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared funct3 encodings and FSM state type for the M-extension unit
package rv32m_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: restoring radix-2 divider datapath, one quotient bit per enabled cycle
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q_next,
  output logic [XLEN-1:0] r_next
);
  logic [XLEN-1:0] r, q, d;
  logic [XLEN:0] shifted;
  logic ge;
  always_comb begin
    shifted = {r, q[XLEN-1]};
    ge = shifted >= {1'b0, d};
    r_next = ge ? XLEN'(shifted - {1'b0, d}) : shifted[XLEN-1:0];
    q_next = {q[XLEN-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
    end else if (load) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
    end else if (en) begin
      r <= r_next;
      q <= q_next;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M unit with single-cycle multiply and 32-cycle iterative divide
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_n;
  logic [4:0] cnt, rd_q;
  logic neg_q, neg_r, rem_sel;
  logic is_div, sgn_div, a_neg, b_neg, div_zero, ovf, fast, accept, last;
  logic mul_sa, mul_sb;
  logic [XLEN-1:0] a_mag, b_mag, fast_res, div_res, q_next, r_next;
  logic signed [2*XLEN-1:0] prod;
  always_comb begin
    is_div = funct3[2];
    sgn_div = is_div && !funct3[0];
    a_neg = sgn_div && op_a[XLEN-1];
    b_neg = sgn_div && op_b[XLEN-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
    div_zero = op_b == '0;
    ovf = sgn_div && op_a == MIN_INT && op_b == '1;
    fast = !is_div || div_zero || ovf;
    mul_sa = funct3 == F3_MULH || funct3 == F3_MULHSU;
    mul_sb = funct3 == F3_MULH;
    prod = $signed({mul_sa && op_a[XLEN-1], op_a}) * $signed({mul_sb && op_b[XLEN-1], op_b});
    fast_res = !is_div ? (funct3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
             : div_zero ? (funct3[1] ? op_a : '1)
             : (funct3[1] ? '0 : MIN_INT);
    accept = start && !flush && state != DIV;
    last = state == DIV && cnt == 5'd31;
    div_res = rem_sel ? (neg_r ? -r_next : r_next) : (neg_q ? -q_next : q_next);
    state_n = flush ? IDLE
            : state == DIV ? (last ? DONE : DIV)
            : accept ? (fast ? DONE : DIV) : IDLE;
    busy = state == DIV;
    done = state == DONE;
  end
  div_iter #(.XLEN(XLEN)) u_div (
    .clk(clk),
    .rst(rst),
    .load(accept && !fast),
    .en(state == DIV),
    .dividend(a_mag),
    .divisor(b_mag),
    .q_next(q_next),
    .r_next(r_next)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      result <= '0;
      rd_out <= '0;
      rd_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem_sel <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == DIV && !last) ? cnt + 5'd1 : '0;
      if (accept) begin
        rd_q <= rd_in;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        rem_sel <= funct3[1];
      end
      if (accept && fast) begin
        result <= fast_res;
        rd_out <= rd_in;
      end else if (last && !flush) begin
        result <= div_res;
        rd_out <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0] rd_in = '0;
  logic busy, done;
  logic [31:0] result;
  logic [4:0] rd_out;
  int nchk = 0, nerr = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fast_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
    issue(f, a, b, rd);
    nchk++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp || rd_out !== rd) begin
      nerr++;
      $display("FAIL %s: done=%b busy=%b result=%h rd=%0d, want done=1 busy=0 result=%h rd=%0d",
               name, done, busy, result, rd_out, exp, rd);
    end
    @(negedge clk);
    nchk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_pulse: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic div_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int bad = 0;
    issue(f, a, b, rd);
    for (int i = 0; i < 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    nchk++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL %s_busy: %0d of 32 cycles wrong, want busy=1 done=0 throughout", name, bad);
    end
    nchk++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp || rd_out !== rd) begin
      nerr++;
      $display("FAIL %s: done=%b busy=%b result=%h rd=%0d, want done=1 busy=0 result=%h rd=%0d",
               name, done, busy, result, rd_out, exp, rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
      nerr++;
      $display("FAIL reset: busy=%b done=%b result=%h rd=%0d, want all 0", busy, done, result, rd_out);
    end
  endtask

  task automatic test_mul();
    fast_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
    fast_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000);
    fast_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE);
    fast_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF);
  endtask

  task automatic test_div();
    div_op("div", 3'b100, 32'hFFFFFFEC, 32'd6, 5'd10, 32'hFFFFFFFD);
    @(negedge clk);
    div_op("rem", 3'b110, 32'hFFFFFFEC, 32'd6, 5'd11, 32'hFFFFFFFE);
    @(negedge clk);
    div_op("divu", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14);
    @(negedge clk);
    div_op("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2);
    @(negedge clk);
  endtask

  task automatic test_corner();
    fast_op("divu_by0", 3'b101, 32'd100, 32'd0, 5'd14, 32'hFFFFFFFF);
    fast_op("remu_by0", 3'b111, 32'd100, 32'd0, 5'd15, 32'd100);
    fast_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000);
    fast_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h0);
  endtask

  task automatic test_flush();
    int bad = 0;
    issue(3'b101, 32'd1000, 32'd3, 5'd20);
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        issue(3'b000, 32'd2, 32'd3, 5'd21);
        c++;
      end
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (c < 10) @(negedge clk);
    end
    nchk++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL flush_pre: %0d cycles wrong before flush, want busy=1 done=0", bad);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL flush_kill: busy=%b done=%b, want 0 0", busy, done);
    end
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL flush_nodone: busy=%b done=%b, want 0 0", busy, done);
    end
    fast_op("flush_mul", 3'b000, 32'd6, 32'd7, 5'd9, 32'd42);
  endtask

  task automatic test_back_to_back();
    issue(3'b100, 32'd50, 32'd3, 5'd22);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin
      nerr++;
      $display("FAIL rst_mid: busy=%b done=%b result=%h rd=%0d, want all 0", busy, done, result, rd_out);
    end
    div_op("b2b_first", 3'b100, 32'd100, 32'hFFFFFFF9, 5'd23, 32'hFFFFFFF2);
    div_op("b2b_second", 3'b110, 32'hFFFFFF9C, 32'd7, 5'd24, 32'hFFFFFFFE);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_corner();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
